attn_head_engine: RTL and testbench

//  Next-generation single-head attention engine, parametrised in sequence length N, head dim D and data width.

---
 rtl/attn_pkg.sv | 28 ++
 rtl/attn_quant.sv | 37 +++
 rtl/attn_head_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_attn_head_engine.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/attn_pkg.sv
// Shared definitions for the single-head attention engine.
//   state_t  : FSM encoding, 3 bits (ST_IDLE..ST_HOLD)
//   MODE_*   : normalisation mode encodings (value 3 behaves as MODE_BYP)
//   elem_idx : flat element index for row-major (r, c) packing
package attn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCORE  = 3'd1,
        ST_QUANT1 = 3'd2,
        ST_MIN    = 3'd3,
        ST_NORM   = 3'd4,
        ST_WEIGH  = 3'd5,
        ST_QUANT2 = 3'd6,
        ST_HOLD   = 3'd7
    } state_t;

    localparam logic [1:0] MODE_SQ  = 2'd0;
    localparam logic [1:0] MODE_LIN = 2'd1;
    localparam logic [1:0] MODE_BYP = 2'd2;

    // Element (r, c) of a matrix with 'cols' columns sits at
    // [elem_idx(r, c, cols) * DW +: DW] in the packed port vectors.
    function automatic int elem_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/attn_quant.sv
// Round-half-up requantisation with saturation.
//   i_x [IW-1:0] : unsigned fixed-point value with FRAC fraction bits
//   o_y [DW-1:0] : i_x >> FRAC, rounded half-up, clamped to 2^DW-1
// Purely combinational; one instance per grid cell, shared by the
// score, normalisation and output requantisation steps.
module attn_quant #(
    parameter int IW   = 36,
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic [IW-1:0] i_x,
    output logic [DW-1:0] o_y
);

    logic [DW:0] w_sum;
    logic        w_hi;

    // Extra MSB of w_sum catches the carry out of rounding an all-ones value.
    assign w_sum = {1'b0, i_x[FRAC +: DW]} + {{DW{1'b0}}, i_x[FRAC-1]};

    generate
        if (IW > FRAC + DW) begin : g_hi
            assign w_hi = |i_x[IW-1:FRAC+DW];
        end else begin : g_no_hi
            assign w_hi = 1'b0;
        end

        // Bits below the rounding bit do not influence the result.
        if (FRAC >= 2) begin : g_lsb
            logic w_unused_lsb;
            assign w_unused_lsb = ^i_x[FRAC-2:0];
        end
    endgenerate

    assign o_y = (w_hi || w_sum[DW]) ? {DW{1'b1}} : w_sum[DW-1:0];

endmodule

// File: rtl/attn_head_engine.sv
// Single-head attention engine: O = quant(P * V), P = norm(quant(Q * K^T)).
//   clk, rst          : clock, synchronous active-high reset
//   start / in_ready  : job request, accepted when both high (in_ready only in IDLE)
//   mode, causal      : normalisation mode and causal mask, latched on accept
//   q_in, k_in, v_in  : N x D operand matrices, row-major DW-bit elements
//   out_data          : N x D result, held from QUANT2 until the next QUANT2
//   out_valid / out_ready : result handshake
//   o_dbg_state       : current FSM state
// Handshake rule: a transfer happens on a rising edge where valid (start or
// out_valid) and ready (in_ready or out_ready) are both high; valid never
// depends on ready and, once raised, out_valid/out_data hold until transfer.
module attn_head_engine
    import attn_pkg::*;
#(
    parameter int N    = 8,
    parameter int D    = 4,
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic              causal,
    input  logic [N*D*DW-1:0] q_in,
    input  logic [N*D*DW-1:0] k_in,
    input  logic [N*D*DW-1:0] v_in,
    output logic [N*D*DW-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        o_dbg_state
);

    localparam int AW = 2 * DW + $clog2(N) + 1;
    localparam int CW = $clog2(N + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_mode;
    logic            r_causal;
    logic [DW-1:0]   r_q [N][D];
    logic [DW-1:0]   r_k [N][D];
    logic [DW-1:0]   r_v [N][D];
    logic [AW-1:0]   r_acc [N][N];
    logic [DW-1:0]   r_s [N][N];
    logic [DW-1:0]   r_p [N][N];
    logic [DW-1:0]   r_m [N];

    logic [DW-1:0]   w_a [N];
    logic [DW-1:0]   w_b [N];
    logic [DW-1:0]   w_min [N];
    logic [DW-1:0]   w_qout [N][N];
    logic [DW-1:0]   w_e [N][N];
    logic [2*DW-1:0] w_prod [N][N];
    logic            w_last_score;
    logic            w_last_weigh;

    assign w_last_score = (r_cnt == CW'(D - 1));
    assign w_last_weigh = (r_cnt == CW'(N - 1));
    assign o_dbg_state  = r_state;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (start) w_state_nxt = ST_SCORE;
            end
            ST_SCORE:  if (w_last_score) w_state_nxt = ST_QUANT1;
            ST_QUANT1: w_state_nxt = ST_MIN;
            ST_MIN:    w_state_nxt = ST_NORM;
            ST_NORM:   w_state_nxt = ST_WEIGH;
            ST_WEIGH:  if (w_last_weigh) w_state_nxt = ST_QUANT2;
            ST_QUANT2: w_state_nxt = ST_HOLD;
            ST_HOLD:   if (out_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- broadcast operands ----------------
    // Row operand w_a[i] and column operand w_b[j] feed every cell of the
    // grid. SCORE: Q column k against K column k. WEIGH: P column j against
    // V row j; grid columns d >= D get 0 so their accumulators stay at 0.
    always_comb begin
        for (int x = 0; x < N; x++) begin
            w_a[x] = '0;
            w_b[x] = '0;
        end
        if (r_state == ST_SCORE) begin
            for (int k = 0; k < D; k++) begin
                if (r_cnt == CW'(k)) begin
                    for (int x = 0; x < N; x++) begin
                        w_a[x] = r_q[x][k];
                        w_b[x] = r_k[x][k];
                    end
                end
            end
        end else if (r_state == ST_WEIGH) begin
            for (int j = 0; j < N; j++) begin
                if (r_cnt == CW'(j)) begin
                    for (int x = 0; x < N; x++) begin
                        w_a[x] = r_p[x][j];
                    end
                    for (int d = 0; d < D; d++) begin
                        w_b[d] = r_v[j][d];
                    end
                end
            end
        end
    end

    // Column minimum of the requantised scores.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_min[j] = r_s[0][j];
            for (int i = 1; i < N; i++) begin
                if (r_s[i][j] < w_min[j]) w_min[j] = r_s[i][j];
            end
        end
    end

    // ---------------- per-cell logic ----------------
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            for (genvar gj = 0; gj < N; gj++) begin : g_col
                logic [DW-1:0]   w_diff;
                logic [2*DW-1:0] w_sq;
                logic [AW-1:0]   w_qin;

                // s >= column min by construction, so this never wraps.
                assign w_diff = r_s[gi][gj] - r_m[gj];
                assign w_sq   = {{DW{1'b0}}, w_diff} * {{DW{1'b0}}, w_diff};

                // The quantiser sees the squared distance during NORM and
                // the accumulator otherwise.
                assign w_qin = (r_state == ST_NORM) ?
                               {{(AW-2*DW){1'b0}}, w_sq} : r_acc[gi][gj];

                attn_quant #(
                    .IW   (AW),
                    .DW   (DW),
                    .FRAC (FRAC)
                ) u_quant (
                    .i_x (w_qin),
                    .o_y (w_qout[gi][gj])
                );

                assign w_prod[gi][gj] = {{DW{1'b0}}, w_a[gi]} * {{DW{1'b0}}, w_b[gj]};

                always_comb begin
                    w_e[gi][gj] = r_s[gi][gj];
                    if (r_causal && (gj > gi)) begin
                        w_e[gi][gj] = '0;
                    end else begin
                        case (r_mode)
                            MODE_SQ:  w_e[gi][gj] = w_qout[gi][gj];
                            MODE_LIN: w_e[gi][gj] = w_diff;
                            default:  w_e[gi][gj] = r_s[gi][gj];
                        endcase
                    end
                end
            end
        end
    endgenerate

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_mode    <= '0;
            r_causal  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < N; i++) begin
                r_m[i] <= '0;
                for (int c = 0; c < D; c++) begin
                    r_q[i][c] <= '0;
                    r_k[i][c] <= '0;
                    r_v[i][c] <= '0;
                end
                for (int j = 0; j < N; j++) begin
                    r_acc[i][j] <= '0;
                    r_s[i][j]   <= '0;
                    r_p[i][j]   <= '0;
                end
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode   <= mode;
                        r_causal <= causal;
                        r_cnt    <= '0;
                        for (int i = 0; i < N; i++) begin
                            for (int c = 0; c < D; c++) begin
                                r_q[i][c] <= q_in[elem_idx(i, c, D)*DW +: DW];
                                r_k[i][c] <= k_in[elem_idx(i, c, D)*DW +: DW];
                                r_v[i][c] <= v_in[elem_idx(i, c, D)*DW +: DW];
                            end
                            for (int j = 0; j < N; j++) begin
                                r_acc[i][j] <= '0;
                            end
                        end
                    end
                end
                ST_SCORE, ST_WEIGH: begin
                    r_cnt <= r_cnt + CW'(1);
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            r_acc[i][j] <= r_acc[i][j] + {{(AW-2*DW){1'b0}}, w_prod[i][j]};
                        end
                    end
                end
                ST_QUANT1: begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            r_s[i][j] <= w_qout[i][j];
                        end
                    end
                end
                ST_MIN: begin
                    for (int j = 0; j < N; j++) begin
                        r_m[j] <= w_min[j];
                    end
                end
                ST_NORM: begin
                    r_cnt <= '0;
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            r_p[i][j]   <= w_e[i][j];
                            r_acc[i][j] <= '0;
                        end
                    end
                end
                ST_QUANT2: begin
                    out_valid <= 1'b1;
                    for (int i = 0; i < N; i++) begin
                        for (int d = 0; d < D; d++) begin
                            out_data[elem_idx(i, d, D)*DW +: DW] <= w_qout[i][d];
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_attn_head_engine.sv
// Directed test of attn_head_engine (N=8, D=4, DW=16, FRAC=8).
module tb_attn_head_engine;

    localparam int N  = 8;
    localparam int D  = 4;
    localparam int DW = 16;
    localparam int EW = N * D * DW;
    localparam int LATENCY = D + N + 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_ready;
    logic [1:0]    mode;
    logic          causal;
    logic [EW-1:0] q_in;
    logic [EW-1:0] k_in;
    logic [EW-1:0] v_in;
    logic [EW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    attn_head_engine #(.N(N), .D(D), .DW(DW), .FRAC(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_ready    (in_ready),
        .mode        (mode),
        .causal      (causal),
        .q_in        (q_in),
        .k_in        (k_in),
        .v_in        (v_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_all(input logic [DW-1:0] val);
        for (int e = 0; e < N * D; e++) exp_q.push_back(val);
    endtask

    // ---------------- drivers ----------------
    task automatic fill(input logic [DW-1:0] qv, input logic [DW-1:0] kv, input logic [DW-1:0] vv);
        for (int e = 0; e < N * D; e++) begin
            q_in[e*DW +: DW] = qv;
            k_in[e*DW +: DW] = kv;
            v_in[e*DW +: DW] = vv;
        end
    endtask

    // Accepts one job, scrambles the ports afterwards, measures latency and
    // checks every output element against the expected queue.
    task automatic run_job(input logic [1:0] md, input logic cz, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        mode   = md;
        causal = cz;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        for (int e = 0; e < N * D; e++) begin
            q_in[e*DW +: DW] = DW'($urandom);
            k_in[e*DW +: DW] = DW'($urandom);
            v_in[e*DW +: DW] = DW'($urandom);
        end
        mode   = 2'($urandom_range(0, 3));
        causal = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(LATENCY));
        for (int e = 0; e < N * D; e++) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_exp_q_empty"}, 32'd1, 32'd0);
            end else begin
                chk($sformatf("%s_out%0d", tag, e), 32'(out_data[e*DW +: DW]), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_hs_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_hs_state"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] ev;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        mode = 2'd0; causal = 1'b0;
        q_in = '0; k_in = '0; v_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(|out_data), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // 1: bypass, all ones (1.0)
        fill(16'h0100, 16'h0100, 16'h0100);
        push_all(16'h2000);
        run_job(2'd2, 1'b0, "t1");
        handshake("t1");

        // 2: squared mode, every score equals its column min
        fill(16'h0100, 16'h0100, 16'h0100);
        push_all(16'h0000);
        run_job(2'd0, 1'b0, "t2");
        handshake("t2");

        // 3: linear mode with causal mask, Q row i = i
        fill(16'h0000, 16'h0100, 16'h0100);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < D; c++) begin
                q_in[(r*D+c)*DW +: DW] = DW'(r * 256);
                ev = DW'((r + 1) * r * 1024);
                exp_q.push_back(ev);
            end
        end
        run_job(2'd1, 1'b1, "t3");
        handshake("t3");

        // 4: saturation in both passes
        fill(16'hFFFF, 16'hFFFF, 16'hFFFF);
        push_all(16'hFFFF);
        run_job(2'd2, 1'b0, "t4");
        handshake("t4");

        // 5: round-half-up on a single score
        fill(16'h0000, 16'h0000, 16'h0000);
        q_in[0 +: DW] = 16'h0101;
        k_in[0 +: DW] = 16'h0080;
        for (int c = 0; c < D; c++) v_in[c*DW +: DW] = 16'h0100;
        for (int e = 0; e < N * D; e++) exp_q.push_back((e < D) ? 16'h0081 : 16'h0000);
        run_job(2'd3, 1'b0, "t5");
        handshake("t5");

        // 6a: back-pressure, start ignored while busy
        fill(16'h0100, 16'h0100, 16'h0100);
        push_all(16'h2000);
        run_job(2'd2, 1'b0, "t6");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = (c == 3);
            chk($sformatf("t6_hold_valid%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("t6_hold_in_ready%0d", c), 32'(in_ready), 32'd0);
            chk($sformatf("t6_hold_first%0d", c), 32'(out_data[0 +: DW]), 32'h2000);
            chk($sformatf("t6_hold_last%0d", c), 32'(out_data[(N*D-1)*DW +: DW]), 32'h2000);
        end
        start = 1'b0;
        handshake("t6");
        chk("t6_data_kept", 32'(out_data[5*DW +: DW]), 32'h2000);

        // 6b: reset in the middle of WEIGH
        fill(16'h0100, 16'h0100, 16'h0100);
        @(negedge clk);
        mode = 2'd2; causal = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (D + 5) @(negedge clk);
        chk("t6_in_weigh", 32'(dbg_state), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data", 32'(|out_data), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // 6c: rerun of test 1 after the abort
        fill(16'h0100, 16'h0100, 16'h0100);
        push_all(16'h2000);
        run_job(2'd2, 1'b0, "t6r");
        handshake("t6r");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
